// File: rtl/serv_fetch_pkg.sv
// Shared types for the SERV fetch scheduler: fetch FSM encoding and the
// prefetch FIFO entry layout (PC plus instruction bits [31:2]).
package serv_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int PC_W    = 32;
  localparam int INSN_W  = 30;
  localparam int ENTRY_W = PC_W + INSN_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/serv_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, insn} entries; clear overrides
// push and pop. Callers only push when a slot is free.
module serv_fetch_fifo
  import serv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = CNT_W - 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;

  // NOTE: storage has no reset; the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/serv_fetch_sched.sv
// Fetch scheduler between the SERV Wishbone ibus and serv_decode: issues one
// read at a time, prefetches into a small FIFO, and dispatches one word per strobe.
module serv_fetch_sched
  import serv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_rst,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_dec_rdy,
  output logic        o_dec_en,
  output logic [29:0] o_dec_rdt,
  output logic [31:0] o_dec_pc,
  output logic        o_empty
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]      PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      discard_adr;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occ_next;
  fetch_entry_t     wdata;
  fetch_entry_t     head;
  logic             unused_low_bits;

  assign unused_low_bits = ^{i_ibus_rdt[1:0], i_redirect_pc[1:0]};

  // Redirect wins over dispatch; occupancy after this cycle's pop gates new requests.
  assign pop      = i_dec_rdy && !fifo_empty && !i_redirect;
  assign occ_next = count - CNT_W'(pop);
  assign wdata    = '{pc: fetch_pc, insn: i_ibus_rdt[31:2]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_redirect && (occ_next < DEPTH_C)) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_ibus_ack) begin
          state_next = ST_IDLE;
          push       = !i_redirect;
        end else if (i_redirect) begin
          state_next = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (i_ibus_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The stale cycle must finish at its original address while fetch_pc already
  // points at the redirect target.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc    <= PC_INIT;
      discard_adr <= PC_INIT;
    end else begin
      if (state == ST_REQ && i_redirect && !i_ibus_ack) begin
        discard_adr <= fetch_pc;
      end
      if (i_redirect) begin
        fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  assign o_ibus_cyc = (state != ST_IDLE);
  assign o_ibus_adr = (state == ST_DISCARD) ? discard_adr : fetch_pc;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_dec_en  <= 1'b0;
      o_dec_rdt <= '0;
      o_dec_pc  <= '0;
    end else begin
      o_dec_en <= pop;
      if (pop) begin
        o_dec_rdt <= head.insn;
        o_dec_pc  <= head.pc;
      end
    end
  end

  assign o_empty = fifo_empty;

  serv_fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .clear (i_redirect),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_serv_fetch_sched.sv
// Directed bench for serv_fetch_sched: a per-cycle vector table for steady
// fetch/dispatch, then hand-written sequences for stalls, redirects, wrap and reset.
module tb_serv_fetch_sched;

  logic        clk;
  logic        i_rst;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt;
  logic        i_ibus_ack;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_dec_rdy;
  logic        o_dec_en;
  logic [29:0] o_dec_rdt;
  logic [31:0] o_dec_pc;
  logic        o_empty;

  int total = 0;
  int bad   = 0;

  serv_fetch_sched #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .o_ibus_adr    (o_ibus_adr),
    .o_ibus_cyc    (o_ibus_cyc),
    .i_ibus_rdt    (i_ibus_rdt),
    .i_ibus_ack    (i_ibus_ack),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_dec_rdy     (i_dec_rdy),
    .o_dec_en      (o_dec_en),
    .o_dec_rdt     (o_dec_rdt),
    .o_dec_pc      (o_dec_pc),
    .o_empty       (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst         = 1'b1;
    i_ibus_ack    = 1'b0;
    i_ibus_rdt    = '0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_dec_rdy     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst cyc",   32'(o_ibus_cyc), 0);
    check("rst adr",   o_ibus_adr,      32'h0);
    check("rst en",    32'(o_dec_en),   0);
    check("rst rdt",   32'(o_dec_rdt),  0);
    check("rst pc",    o_dec_pc,        32'h0);
    check("rst empty", 32'(o_empty),    1);
    i_rst = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first cycle with cyc high.
  task automatic wait_cyc(input logic [31:0] exp_adr, input string nm);
    for (int i = 0; i < 50 && !o_ibus_cyc; i++) @(negedge clk);
    check({nm, " cyc"}, 32'(o_ibus_cyc), 1);
    check({nm, " adr"}, o_ibus_adr, exp_adr);
  endtask

  task automatic serve(input logic [31:0] exp_adr, input logic [31:0] rdt,
                       input int waits, input string nm);
    wait_cyc(exp_adr, nm);
    repeat (waits) @(negedge clk);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = rdt;
    @(negedge clk);
    i_ibus_ack = 1'b0;
  endtask

  task automatic wait_dec(input logic [31:0] exp_pc, input logic [29:0] exp_rdt,
                          input string nm);
    for (int i = 0; i < 50 && !o_dec_en; i++) @(negedge clk);
    check({nm, " en"},  32'(o_dec_en), 1);
    check({nm, " pc"},  o_dec_pc, exp_pc);
    check({nm, " rdt"}, 32'(o_dec_rdt), 32'(exp_rdt));
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] rdt;
    logic        rdy;
    logic        cyc;
    logic [31:0] adr;
    logic        en;
    logic [31:0] pc;
    logic [29:0] drt;
    logic        empty;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int nf;
    int n_en;
    int n_cyc;
    logic [31:0] fa [2];

    //            ack  rdt            rdy   cyc   adr           en    pc            drt            empty
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 30'h0,        1'b1};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 30'h0,        1'b1};
    vecs[2]  = '{1'b1, 32'h1111_1113, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 30'h0,        1'b1};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0004, 1'b0, 32'h0, 30'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0, 30'h0444_4444, 1'b1};
    vecs[5]  = '{1'b1, 32'h2222_2223, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 30'h0444_4444, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0008, 1'b0, 32'h0, 30'h0444_4444, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h4, 30'h0888_8888, 1'b1};
    vecs[8]  = '{1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h4, 30'h0888_8888, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_000C, 1'b0, 32'h4, 30'h0888_8888, 1'b0};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h8, 30'h0CCC_CCCC, 1'b1};

    i_rst = 1'b1;

    // Steady stream: one wait state per read, decoder always ready.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      i_ibus_ack = vecs[k].ack;
      i_ibus_rdt = vecs[k].rdt;
      i_dec_rdy  = vecs[k].rdy;
      check($sformatf("v%0d cyc", k),   32'(o_ibus_cyc), 32'(vecs[k].cyc));
      check($sformatf("v%0d adr", k),   o_ibus_adr,      vecs[k].adr);
      check($sformatf("v%0d en", k),    32'(o_dec_en),   32'(vecs[k].en));
      check($sformatf("v%0d pc", k),    o_dec_pc,        vecs[k].pc);
      check($sformatf("v%0d rdt", k),   32'(o_dec_rdt),  32'(vecs[k].drt));
      check($sformatf("v%0d empty", k), 32'(o_empty),    32'(vecs[k].empty));
      @(negedge clk);
    end
    i_ibus_ack = 1'b0;

    // Decoder stalled: exactly DEPTH fetches, then one ready pulse frees one slot.
    do_reset();
    nf = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_ibus_cyc) begin
        if (nf < 2) fa[nf] = o_ibus_adr;
        i_ibus_ack = 1'b1;
        i_ibus_rdt = (nf == 0) ? 32'h00A0_0093 : 32'h00B0_0113;
        nf++;
      end else begin
        i_ibus_ack = 1'b0;
      end
      @(negedge clk);
    end
    i_ibus_ack = 1'b0;
    check("full fetch count", nf, 2);
    check("full adr0", fa[0], 32'h0);
    check("full adr1", fa[1], 32'h4);
    check("full cyc idle", 32'(o_ibus_cyc), 0);
    check("full not empty", 32'(o_empty), 0);
    i_dec_rdy = 1'b1;
    @(negedge clk);
    i_dec_rdy = 1'b0;
    check("pulse en",  32'(o_dec_en),  1);
    check("pulse pc",  o_dec_pc,       32'h0);
    check("pulse rdt", 32'(o_dec_rdt), 32'h0028_0024);
    check("pulse cyc", 32'(o_ibus_cyc), 1);
    check("pulse adr", o_ibus_adr,     32'h8);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h00C0_0193;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    n_en  = 0;
    n_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_dec_en) n_en++;
      if (o_ibus_cyc) n_cyc++;
      @(negedge clk);
    end
    check("refill dispatches", n_en, 0);
    check("refill extra reqs", n_cyc, 0);

    // Redirect while a read is stalled: old cycle completes, data dropped.
    do_reset();
    i_dec_rdy = 1'b1;
    wait_cyc(32'h0, "stall req");
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0100;
    @(negedge clk);
    i_redirect = 1'b0;
    check("disc1 cyc", 32'(o_ibus_cyc), 1);
    check("disc1 adr", o_ibus_adr, 32'h0);
    @(negedge clk);
    check("disc2 cyc", 32'(o_ibus_cyc), 1);
    check("disc2 adr", o_ibus_adr, 32'h0);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'hDEAD_BEEF;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    check("disc done cyc", 32'(o_ibus_cyc), 0);
    check("disc done empty", 32'(o_empty), 1);
    check("disc done en", 32'(o_dec_en), 0);
    serve(32'h0000_0100, 32'h1234_5677, 1, "redir fetch");
    wait_dec(32'h0000_0100, 30'h048D_159D, "redir dispatch");

    // Redirect, ack and decoder ready in one cycle: nothing dispatched.
    do_reset();
    serve(32'h0, 32'h0000_0013, 0, "coin w0");
    wait_cyc(32'h4, "coin req");
    check("coin fifo holds word", 32'(o_empty), 0);
    i_ibus_ack    = 1'b1;
    i_ibus_rdt    = 32'hCAFE_0003;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0203;
    i_dec_rdy     = 1'b1;
    @(negedge clk);
    i_ibus_ack = 1'b0;
    i_redirect = 1'b0;
    i_dec_rdy  = 1'b0;
    check("coin en",    32'(o_dec_en),   0);
    check("coin empty", 32'(o_empty),    1);
    check("coin cyc",   32'(o_ibus_cyc), 0);
    @(negedge clk);
    check("coin en later", 32'(o_dec_en), 0);
    wait_cyc(32'h0000_0200, "coin next");
    check("coin pc untouched", o_dec_pc, 32'h0);

    // Fetch PC wraps from the top word to zero.
    do_reset();
    i_dec_rdy     = 1'b1;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    i_redirect = 1'b0;
    serve(32'hFFFF_FFFC, 32'h0000_006F, 0, "wrap fetch");
    wait_dec(32'hFFFF_FFFC, 30'h0000_001B, "wrap dispatch");
    wait_cyc(32'h0, "wrap next");

    // Asynchronous reset mid-request; a stray ack afterwards must be ignored.
    do_reset();
    wait_cyc(32'h0, "mid req");
    i_rst = 1'b1;
    #1;
    check("async cyc", 32'(o_ibus_cyc), 0);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h7777_7777;
    @(negedge clk);
    i_rst = 1'b0;
    check("post rst adr",   o_ibus_adr,   32'h0);
    check("post rst empty", 32'(o_empty), 1);
    @(negedge clk);
    i_ibus_ack = 1'b0;
    check("stray ack empty", 32'(o_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
